// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage with a two-state fetch FSM (REQ / BUF), a one-entry
// skid buffer and the IF/ID pipeline register.
//
// A fetch is held on imem_req/imem_addr until the memory answers with a
// one-cycle imem_ack.
//
// If decode is stalled when the answer arrives, the instruction is parked in
// the skid buffer and the request is dropped until decode frees up. Redirects
// from decode (PCSrcD/nPC) are remembered until the current fetch completes,
// because PCF must not move while a request is outstanding.
//
// Configuration macro: BRANCH_DELAY_SLOT_EN
//   defined   : the instruction being fetched when a redirect is taken
//               (the delay slot) is delivered normally.
//   undefined : that instruction is squashed (delivered as a bubble).
//
// Ports
//   clk         in   clock, all state updates on rising edge
//   reset       in   synchronous active-high reset
//   nPC         in   32  redirect target from decode
//   PCSrcD      in   redirect taken in decode (sampled when StallD=0)
//   StallD      in   hold the IF/ID register
//   imem_req    out  fetch request at imem_addr
//   imem_addr   out  32  current fetch address (PCF)
//   imem_ack    in   one-cycle pulse, imem_rdata valid
//   imem_rdata  in   32  fetched instruction
//   InstrD      out  32  IF/ID instruction
//   PCD         out  32  IF/ID PC
//   PCplus4D    out  32  IF/ID PC+4
//   ValidD      out  IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] nPC,
  input  logic        PCSrcD,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCplus4D,
  output logic        ValidD
);

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_pending_q, redir_pending_d;
  logic        squash_q, squash_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        complete;
  logic        squash;
  logic        slot_kill;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] fetched;

  // slot_kill marks whether a taken redirect kills the instruction that is
  // in flight at the time it is taken.
`ifdef BRANCH_DELAY_SLOT_EN
  assign slot_kill = 1'b0;
`else
  assign slot_kill = 1'b1;
`endif

  assign redirect = PCSrcD & ~StallD;
  // A fetch completes when its instruction is handed to decode: either
  // straight from memory or from the skid buffer.
  assign complete = ~StallD & ((state_q == S_REQ && imem_ack) || state_q == S_BUF);
  // A redirect taken in the completing cycle applies to that same instruction.
  assign squash   = slot_kill & (squash_q | redirect);
  assign pc_plus4 = pc_q + 32'd4;
  // A fresh redirect wins over an older pending one.
  assign next_pc  = redirect ? nPC : (redir_pending_q ? redir_pc_q : pc_plus4);
  assign fetched  = (state_q == S_BUF) ? buf_q : imem_rdata;

  // Request is gated combinationally by reset so that it is low during the
  // reset cycle itself, which makes the memory abort any pending access.
  assign imem_req  = (state_q == S_REQ) & ~reset;
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCplus4D  = pc4_q;
  assign ValidD    = valid_q;

  // Next-state logic for the fetch FSM, PC, redirect bookkeeping, skid
  // buffer and IF/ID register.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_d           = buf_q;
    redir_pc_d      = redir_pc_q;
    redir_pending_d = redir_pending_q;
    squash_d        = squash_q;
    instr_d         = instr_q;
    pcd_d           = pcd_q;
    pc4_d           = pc4_q;
    valid_d         = valid_q;

    if (complete) begin
      // PCF moves only here, so imem_addr is stable while a request is out.
      state_d         = S_REQ;
      pc_d            = next_pc;
      redir_pending_d = 1'b0;
      squash_d        = 1'b0;
      if (squash) begin
        instr_d = 32'd0;
        valid_d = 1'b0;
      end else begin
        instr_d = fetched;
        pcd_d   = pc_q;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end else begin
      if (redirect) begin
        redir_pending_d = 1'b1;
        redir_pc_d      = nPC;
        squash_d        = slot_kill;
      end
      if (state_q == S_REQ && imem_ack && StallD) begin
        buf_d   = imem_rdata;
        state_d = S_BUF;
      end
      if (state_q == S_REQ && !imem_ack && !StallD) begin
        instr_d = 32'd0;
        valid_d = 1'b0;
      end
    end
  end

  // State register for the whole stage; reset discards any outstanding or
  // buffered instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_REQ;
      pc_q            <= RESET_PC;
      buf_q           <= 32'd0;
      redir_pc_q      <= 32'd0;
      redir_pending_q <= 1'b0;
      squash_q        <= 1'b0;
      instr_q         <= 32'd0;
      pcd_q           <= 32'd0;
      pc4_q           <= 32'd0;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      buf_q           <= buf_d;
      redir_pc_q      <= redir_pc_d;
      redir_pending_q <= redir_pending_d;
      squash_q        <= squash_d;
      instr_q         <= instr_d;
      pcd_q           <= pcd_d;
      pc4_q           <= pc4_d;
      valid_q         <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Testbench for if_fetch_stage. A transaction-level model of the fetch stage
// predicts what the DUT should show after every clock edge. The model tracks:
//   - which address is being fetched,
//   - whether an instruction is waiting for decode,
//   - which redirect is pending,
//   - what decode currently holds.
// Predictions are queued by the stimulus process and checked by a separate
// monitor process. Honours BRANCH_DELAY_SLOT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic [31:0] nPC;
  logic        PCSrcD;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        ValidD;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t expQ[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [31:0] curAddr;
  logic [31:0] tgtAddr;
  logic        pending;
  logic        squashCur;
  logic        haveItem;
  logic [31:0] itemData;
  logic        mValid;
  logic [31:0] mInstr;
  logic [31:0] mPc;
  logic [31:0] mPc4;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .nPC        (nPC),
    .PCSrcD     (PCSrcD),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCplus4D   (PCplus4D),
    .ValidD     (ValidD)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the model by one clock edge and
  // queues the prediction for what the DUT must show after that edge.
  task automatic applyStimulus(input logic rst, input logic stall, input logic pcsrc,
                               input logic [31:0] target, input logic ackWanted);
    logic        ack;
    logic [31:0] rdata;
    exp_t        e;
    ack   = ackWanted && (rst || !haveItem);
    rdata = $urandom;
    reset      = rst;
    StallD     = stall;
    PCSrcD     = pcsrc;
    nPC        = target;
    imem_ack   = ack;
    imem_rdata = rdata;

    if (rst) begin
      curAddr   = RESET_PC;
      pending   = 1'b0;
      squashCur = 1'b0;
      haveItem  = 1'b0;
      mValid    = 1'b0;
      mInstr    = 32'd0;
      mPc       = 32'd0;
      mPc4      = 32'd0;
    end else begin
      if (pcsrc && !stall) begin
        tgtAddr = target;
        pending = 1'b1;
`ifndef BRANCH_DELAY_SLOT_EN
        squashCur = 1'b1;
`endif
      end
      if (ack && !haveItem) begin
        haveItem = 1'b1;
        itemData = rdata;
      end
      if (!stall) begin
        if (haveItem && !squashCur) begin
          mValid = 1'b1;
          mInstr = itemData;
          mPc    = curAddr;
          mPc4   = curAddr + 32'd4;
        end else begin
          mValid = 1'b0;
          mInstr = 32'd0;
        end
        if (haveItem) begin
          curAddr   = pending ? tgtAddr : curAddr + 32'd4;
          pending   = 1'b0;
          squashCur = 1'b0;
          haveItem  = 1'b0;
        end
      end
    end

    e.req   = !rst && !haveItem;
    e.addr  = curAddr;
    e.valid = mValid;
    e.instr = mInstr;
    e.pc    = mPc;
    e.pc4   = mPc4;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("imem_req",  {31'd0, imem_req}, {31'd0, e.req});
    cmp("imem_addr", imem_addr,         e.addr);
    cmp("ValidD",    {31'd0, ValidD},   {31'd0, e.valid});
    cmp("InstrD",    InstrD,            e.instr);
    cmp("PCD",       PCD,               e.pc);
    cmp("PCplus4D",  PCplus4D,          e.pc4);
  endtask

  // Monitor: shortly after each rising edge, pop the prediction for that
  // edge and compare it against the DUT outputs.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed scenarios first, then a long randomized run with occasional
  // resets, stalls and redirects (including targets near the 32-bit wrap).
  initial begin
    logic        rst, stall, pcsrc, ack;
    logic [31:0] target;
    curAddr = RESET_PC; tgtAddr = 32'd0; pending = 1'b0; squashCur = 1'b0;
    haveItem = 1'b0; itemData = 32'd0;
    mValid = 1'b0; mInstr = 32'd0; mPc = 32'd0; mPc4 = 32'd0;

    // Reset; second reset cycle carries an ack that must be ignored.
    applyStimulus(1, 0, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 32'd0, 1);
    // Back-to-back fetches 0x3000, 0x3004.
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);
    // 0x3008 acked under stall -> skid buffer, then released.
    applyStimulus(0, 1, 0, 32'd0, 1);
    applyStimulus(0, 1, 0, 32'd0, 0);
    applyStimulus(0, 0, 0, 32'd0, 0);
    // 0x300C with ack delayed three cycles.
    applyStimulus(0, 0, 0, 32'd0, 0);
    applyStimulus(0, 0, 0, 32'd0, 0);
    applyStimulus(0, 0, 0, 32'd0, 0);
    applyStimulus(0, 0, 0, 32'd0, 1);
    // Redirect to 0x3100 while 0x3010 is outstanding, then it completes.
    applyStimulus(0, 0, 1, 32'h0000_3100, 0);
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);
    // Reset in the middle of the fetch at 0x3104.
    applyStimulus(0, 0, 0, 32'd0, 0);
    applyStimulus(1, 0, 0, 32'd0, 0);
    applyStimulus(0, 0, 0, 32'd0, 0);
    // Same-cycle redirect to the top of memory, then wrap to 0.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);
    // Redirect taken while an instruction sits in the skid buffer, then a
    // second redirect overwriting a pending one.
    applyStimulus(0, 1, 0, 32'd0, 1);
    applyStimulus(0, 0, 1, 32'h0000_4000, 0);
    applyStimulus(0, 0, 1, 32'h0000_5000, 0);
    applyStimulus(0, 0, 1, 32'h0000_6000, 0);
    applyStimulus(0, 0, 0, 32'd0, 1);
    applyStimulus(0, 0, 0, 32'd0, 1);

    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      pcsrc  = ($urandom_range(0, 5) == 0);
      ack    = ($urandom_range(0, 2) != 0);
      target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + {28'd0, $urandom_range(0, 3), 2'b00}
                                          : {$urandom, 2'b00} >> 2 << 2;
      applyStimulus(rst, stall, pcsrc, target, ack);
    end
    applyStimulus(0, 0, 0, 32'd0, 0);

    repeat (2) @(negedge clk);
    cmp("queue_drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
